// File: rtl/ofr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ofr_queue
//  Brief    : Output-result FIFO with last-value register, occupancy,
//             sticky overflow and control-word driven clear.
//  Revision : 1.0 - initial release
// ============================================================================
module ofr_queue #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 4,
   parameter int LOAD_BIT = 12,
   parameter int CLR_BIT  = 13
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                control_signal,
   input  logic [WIDTH-1:0]           from_ALU,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           BUFF_OFR,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       overflow
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH+1);
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wp;
   logic [c_PTR_W-1:0] r_rp;
   logic [c_CNT_W-1:0] r_count;
   logic               r_overflow;
   logic [WIDTH-1:0]   r_buff;

   logic w_push;
   logic w_pop;
   logic w_clr;
   logic w_full;
   logic w_valid;
   logic w_write;
   logic w_unused_ctrl;

   assign w_push  = control_signal[LOAD_BIT];
   assign w_clr   = control_signal[CLR_BIT];
   assign w_full  = (r_count == c_DEPTH_CNT);
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & out_ready;
   // A push into a full queue still lands when the head leaves on the same edge.
   assign w_write = w_push & (~w_full | w_pop);

   assign w_unused_ctrl = ^control_signal;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_buff     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_buff <= from_ALU;
         end
         if (w_clr) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
         end else begin
            if (w_pop) begin
               r_rp <= r_rp + c_PTR_W'(1);
            end
            if (w_write) begin
               r_mem[r_wp] <= from_ALU;
               r_wp        <= r_wp + c_PTR_W'(1);
            end
            if (w_push && w_full && !w_pop) begin
               r_overflow <= 1'b1;
            end
            if (w_write && !w_pop) begin
               r_count <= r_count + c_CNT_W'(1);
            end else if (!w_write && w_pop) begin
               r_count <= r_count - c_CNT_W'(1);
            end
         end
      end
   end

   assign out_data  = w_valid ? r_mem[r_rp] : '0;
   assign out_valid = w_valid;
   assign BUFF_OFR  = r_buff;
   assign count     = r_count;
   assign full      = w_full;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ofr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ofr_queue
//  Brief    : Directed self-checking bench for ofr_queue (DEPTH 4, WIDTH 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ofr_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] control_signal;
   logic [15:0] from_ALU;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] BUFF_OFR;
   logic [2:0]  count;
   logic        full;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   ofr_queue #(.WIDTH(16), .DEPTH(4), .LOAD_BIT(12), .CLR_BIT(13)) dut (
      .clk            (clk),
      .rst            (rst),
      .control_signal (control_signal),
      .from_ALU       (from_ALU),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .BUFF_OFR       (BUFF_OFR),
      .count          (count),
      .full           (full),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic push, input logic clr, input logic [15:0] d, input logic rdy);
      control_signal     = 32'h0;
      control_signal[12] = push;
      control_signal[13] = clr;
      from_ALU           = d;
      out_ready          = rdy;
   endtask

   initial begin
      logic [15:0] exp_drain [4];
      exp_drain = '{16'h00A1, 16'h00A2, 16'h00A3, 16'hBEEF};

      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      step();
      step();
      rst = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_buff", 32'(BUFF_OFR), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'd0);

      // Basic fill with consumer stalled, then drain.
      drive(1'b1, 1'b0, 16'h1111, 1'b0); step();
      chk("fill1_count", 32'(count), 32'd1);
      chk("fill1_data", 32'(out_data), 32'h1111);
      drive(1'b1, 1'b0, 16'h2222, 1'b0); step();
      chk("fill2_count", 32'(count), 32'd2);
      chk("fill2_data", 32'(out_data), 32'h1111);
      drive(1'b1, 1'b0, 16'h3333, 1'b0); step();
      chk("fill3_count", 32'(count), 32'd3);
      chk("fill3_data", 32'(out_data), 32'h1111);
      chk("fill3_buff", 32'(BUFF_OFR), 32'h3333);
      drive(1'b0, 1'b0, 16'h0, 1'b1); step();
      chk("drain1_data", 32'(out_data), 32'h2222);
      chk("drain1_count", 32'(count), 32'd2);
      step();
      chk("drain2_data", 32'(out_data), 32'h3333);
      step();
      chk("drain3_count", 32'(count), 32'd0);
      chk("drain3_data", 32'(out_data), 32'h0);
      chk("drain3_valid", 32'(out_valid), 32'd0);

      // Fill to DEPTH, then one dropped push.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 16'h00A0 + 16'(i), 1'b0); step();
      end
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ovf0", 32'(overflow), 32'd0);
      drive(1'b1, 1'b0, 16'h00A4, 1'b0); step();
      chk("drop_ovf", 32'(overflow), 32'd1);
      chk("drop_count", 32'(count), 32'd4);
      chk("drop_buff", 32'(BUFF_OFR), 32'h00A4);
      chk("drop_head", 32'(out_data), 32'h00A0);

      // Push and pop together while full.
      drive(1'b1, 1'b0, 16'hBEEF, 1'b1); step();
      chk("fullpp_count", 32'(count), 32'd4);
      chk("fullpp_ovf", 32'(overflow), 32'd1);
      chk("fullpp_head", 32'(out_data), 32'h00A1);
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("fulldrain_data", 32'(out_data), 32'(exp_drain[i]));
         step();
      end
      chk("fulldrain_count", 32'(count), 32'd0);

      // Clear with push while holding entries and overflow.
      drive(1'b1, 1'b0, 16'h0011, 1'b0); step();
      drive(1'b1, 1'b0, 16'h0022, 1'b0); step();
      drive(1'b1, 1'b0, 16'h0033, 1'b0); step();
      chk("preclr_count", 32'(count), 32'd3);
      chk("preclr_ovf", 32'(overflow), 32'd1);
      drive(1'b1, 1'b1, 16'h5555, 1'b1); step();
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_buff", 32'(BUFF_OFR), 32'h5555);
      drive(1'b1, 1'b0, 16'h6666, 1'b0); step();
      chk("postclr_data", 32'(out_data), 32'h6666);
      chk("postclr_count", 32'(count), 32'd1);
      drive(1'b0, 1'b0, 16'h0, 1'b1); step();
      chk("postclr_empty", 32'(count), 32'd0);

      // Streaming across pointer wrap: each value appears one edge after its push.
      for (int i = 1; i <= 12; i++) begin
         drive(1'b1, 1'b0, 16'(i), 1'b1); step();
         chk("stream_data", 32'(out_data), 32'(i));
         chk("stream_count", 32'(count), 32'd1);
      end
      drive(1'b0, 1'b0, 16'h0, 1'b1); step();
      chk("stream_end_count", 32'(count), 32'd0);

      // Reset mid-stream with push and ready asserted.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 16'h00C0 + 16'(i), 1'b0); step();
      end
      drive(1'b0, 1'b0, 16'h0, 1'b1); step(); step();
      chk("prerst_count", 32'(count), 32'd2);
      chk("prerst_ovf", 32'(overflow), 32'd1);
      chk("prerst_head", 32'(out_data), 32'h00C2);
      rst = 1'b1;
      drive(1'b1, 1'b0, 16'h0099, 1'b1); step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_buff", 32'(BUFF_OFR), 32'h0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data", 32'(out_data), 32'h0);
      chk("midrst_full", 32'(full), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ofr_queue.md
# ofr_queue

Parametrised output-result buffer for the CPU datapath: captures ALU results into a FIFO of depth DEPTH when the control word's load bit is set. Results drain through a valid/ready port to the consumer, for example an output/display stage or the testbench monitor. A "last value" register is kept for direct observation, matching the single-register output-result behaviour it replaces. The block adds occupancy tracking, a sticky overflow flag and a control-driven clear.

## Interface

Parameters:
- WIDTH, 16: data width of ALU result and every entry.
- DEPTH, 4: number of entries; power of two, ≥2.
- LOAD_BIT, 12: index in control_signal that requests a capture.
- CLR_BIT, 13: index in control_signal that flushes the queue; must differ from LOAD_BIT.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- control_signal  input  32  microcode control word; only bits LOAD_BIT and CLR_BIT are used.
- from_ALU  input  WIDTH  ALU result to capture.
- out_data  output  WIDTH  head entry; 0 when empty.
- out_valid  output  1  queue non-empty.
- out_ready  input  1  consumer accepts head this cycle.
- BUFF_OFR  output  WIDTH  most recent from_ALU value sampled on a load.
- count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a load was dropped because the queue was full.

## Operation

Per-cycle signals:
- push = control_signal[LOAD_BIT].
- pop = out_valid & out_ready.
- clr = control_signal[CLR_BIT].

Storage and pointers:
- Storage is a circular buffer with write pointer wp and read pointer rp, each log2(DEPTH) bits, plus count.
- Pointers wrap from DEPTH-1 to 0 by natural modulo.

Priority per rising edge, after rst:
- clr = 1: wp = rp = count = 0 and overflow = 0. Push and pop in the same cycle are ignored. BUFF_OFR still updates if push = 1.
- Otherwise:
  - pop: rp += 1.
  - push with count < DEPTH, or push with pop in the same cycle: write from_ALU at wp, wp += 1.
  - push with full and no pop: data is dropped, overflow <= 1, pointers and count unchanged.
  - count updates by +1 on push only, −1 on pop only, unchanged on both or neither.

Other behaviour:
- BUFF_OFR <= from_ALU whenever push = 1, including dropped pushes and clear cycles. It is otherwise held and is never cleared except by rst.
- pop while empty cannot occur because out_valid = 0. out_ready is ignored when empty.
- out_data is driven combinationally from entry rp when count > 0, else 0.
- full = (count == DEPTH). out_valid = (count != 0). Both are derived from registered count, so they carry no combinational path from inputs.
- No path from from_ALU or control_signal to any output within the same cycle.

## Timing

- Reset (rst high at a rising edge): count = 0, wp = rp = 0, overflow = 0, BUFF_OFR = 0, all storage entries = 0.
  - Resulting outputs: out_valid = 0, full = 0, out_data = 0.
  - rst overrides clr, push and pop. Reset mid-stream discards all queued data.
- Capture latency: a push at edge N makes the value visible on out_data/out_valid after edge N when the queue was empty. There is no same-cycle bypass.
- Pop latency: when out_valid & out_ready is sampled at edge N, the next entry, or 0/invalid, appears after edge N.
- Throughput: one push and one pop per cycle sustained, at any occupancy including full and empty.
  - Empty + push + ready: the entry is held one cycle before it can pop.
- overflow sets on the edge of the dropped push. It stays set until clr or rst.
- Handshake: out_data and out_valid are stable while out_valid = 1 and out_ready = 0.

## Test plan

- Reset, then push 0x1111, 0x2222, 0x3333 on three consecutive cycles with out_ready = 0:
  - count goes 1, 2, 3; BUFF_OFR = 0x3333.
  - out_data = 0x1111 throughout.
  - Raising out_ready then drains 0x1111, 0x2222, 0x3333 on successive edges, after which count = 0 and out_data = 0.
- With DEPTH = 4, push 0xA0..0xA4 with out_ready = 0:
  - full = 1 after the 4th push; the 5th push sets overflow = 1 and leaves count = 4.
  - BUFF_OFR = 0xA4; the drain yields 0xA0..0xA3 only.
- Full queue, push 0xBEEF with out_ready = 1 in the same cycle:
  - Head pops, 0xBEEF is accepted, count stays 4, overflow unchanged.
  - 0xBEEF is the last entry drained.
- Continuous push and pop for 3·DEPTH cycles with values 1, 2, 3, …:
  - Output order is preserved across pointer wrap.
  - count stays at 1 after the first edge.
- With 3 entries and overflow = 1, assert clr together with push 0x5555:
  - count = 0, overflow = 0, out_valid = 0, BUFF_OFR = 0x5555.
  - Next push 0x6666 gives out_data = 0x6666.
- With 2 entries queued, assert rst for one cycle together with push and out_ready:
  - All outputs return to reset values: count = 0, BUFF_OFR = 0, overflow = 0.
